xgriscv_muldiv: RTL

- Iterative RV32M multiply/divide unit, parametrised in XLEN, for the next-generation xgriscv core.
- Sits beside the ALU in the execute stage; the core stalls on ready/done.
- Radix-2 shift-add multiply and restoring divide, one bit per cycle, sign fix-up in a separate cycle.
- Division special cases (divide-by-zero, signed overflow) complete on a short fixed path.

---
 rtl/xgriscv_pkg.sv | 37 +++
 rtl/xgriscv_muldiv_core_step.sv | 36 +++
 rtl/xgriscv_muldiv.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/xgriscv_pkg.sv
// Shared types and constants for the xgriscv M-extension unit.
// Holds the op/state enums and small op-decode helpers.
package xgriscv_pkg;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } muldiv_op_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CALC  = 2'd1,
    FIXUP = 2'd2,
    DONE  = 2'd3
  } muldiv_state_e;

  localparam int MULDIV_SPECIAL_LAT = 2;

  // rs1 is signed for MULH, MULHSU, DIV, REM
  function automatic logic op_signed_a(input logic [2:0] f3);
    return (f3 == OP_MULH) || (f3 == OP_MULHSU) ||
           (f3 == OP_DIV)  || (f3 == OP_REM);
  endfunction

  // rs2 is signed for MULH, DIV, REM
  function automatic logic op_signed_b(input logic [2:0] f3);
    return (f3 == OP_MULH) || (f3 == OP_DIV) ||
           (f3 == OP_REM);
  endfunction

endpackage

// File: rtl/xgriscv_muldiv_core_step.sv
// One radix-2 iteration: shift-add multiply or restoring divide.
// Ports: div (mode), hi/lo (accumulator pair), dsr (multiplicand/divisor), hi_nxt/lo_nxt.
module xgriscv_muldiv_core_step #(
  parameter int XLEN = 32
) (
  input  logic            div,
  input  logic [XLEN-1:0] hi,
  input  logic [XLEN-1:0] lo,
  input  logic [XLEN-1:0] dsr,
  output logic [XLEN-1:0] hi_nxt,
  output logic [XLEN-1:0] lo_nxt
);

  logic [XLEN:0] sum;
  logic [XLEN:0] rem_sh;
  logic [XLEN:0] diff;

  always_comb begin
    // multiply: {hi,lo} holds partial product and remaining multiplier
    sum    = {1'b0, hi} + (lo[0] ? {1'b0, dsr} : '0);
    // divide: hi is partial remainder, lo shifts dividend out and quotient in
    rem_sh = {hi, lo[XLEN-1]};
    diff   = rem_sh - {1'b0, dsr};
    hi_nxt = '0;
    lo_nxt = '0;
    if (div) begin
      // borrow out (diff msb) means the trial subtract failed: restore
      hi_nxt = diff[XLEN] ? rem_sh[XLEN-1:0] : diff[XLEN-1:0];
      lo_nxt = {lo[XLEN-2:0], ~diff[XLEN]};
    end else begin
      hi_nxt = sum[XLEN:1];
      lo_nxt = {sum[0], lo[XLEN-1:1]};
    end
  end

endmodule

// File: rtl/xgriscv_muldiv.sv
// Iterative RV32M multiply/divide unit, one bit per cycle plus a sign fix-up cycle.
// Ports: clk, reset, start, funct3, a, b, flush -> ready, busy, done, result.
module xgriscv_muldiv
  import xgriscv_pkg::*;
#(
  parameter  int XLEN  = 32,
  localparam int CNT_W = $clog2(XLEN) + 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            flush,
  output logic            ready,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  muldiv_state_e state;
  muldiv_op_e    op;
  logic [CNT_W-1:0] cnt;
  logic            sa;
  logic            sb;
  logic [XLEN-1:0] hi;
  logic [XLEN-1:0] lo;
  logic [XLEN-1:0] dsr;

  logic            accept;
  logic            div_op;
  logic            na;
  logic            nb;
  logic [XLEN-1:0] mag_a;
  logic [XLEN-1:0] mag_b;
  logic            div_zero;
  logic            div_ovf;
  logic [XLEN-1:0] hi_nxt;
  logic [XLEN-1:0] lo_nxt;
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0] quo;
  logic [XLEN-1:0] rmd;
  logic [XLEN-1:0] res_nxt;

  assign ready  = (state == IDLE) || (state == DONE);
  assign busy   = (state == CALC) || (state == FIXUP);
  assign accept = start && ready && !flush;

  always_comb begin
    div_op   = funct3[2];
    na       = op_signed_a(funct3) && a[XLEN-1];
    nb       = op_signed_b(funct3) && b[XLEN-1];
    mag_a    = na ? (~a + 1'b1) : a;
    mag_b    = nb ? (~b + 1'b1) : b;
    div_zero = div_op && (b == '0);
    // only DIV/REM (funct3[0]==0) can overflow
    div_ovf  = div_op && !funct3[0] &&
               (a == {1'b1, {(XLEN-1){1'b0}}}) &&
               (b == '1);
  end

  xgriscv_muldiv_core_step #(
    .XLEN(XLEN)
  ) u_step (
    .div    (op[2]),
    .hi     (hi),
    .lo     (lo),
    .dsr    (dsr),
    .hi_nxt (hi_nxt),
    .lo_nxt (lo_nxt)
  );

  // special cases park their answer in hi/lo with sign flags clear,
  // so fix-up selection is the same as for iterated results
  always_comb begin
    prod = (sa ^ sb) ? (~{hi, lo} + 1'b1) : {hi, lo};
    quo  = (sa ^ sb) ? (~lo + 1'b1) : lo;
    rmd  = sa ? (~hi + 1'b1) : hi;
    res_nxt = '0;
    unique case (1'b1)
      (op == OP_MUL):          res_nxt = prod[XLEN-1:0];
      (!op[2] && op != OP_MUL): res_nxt = prod[2*XLEN-1:XLEN];
      (op[2] && !op[1]):       res_nxt = quo;
      (op[2] && op[1]):        res_nxt = rmd;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      op     <= OP_MUL;
      cnt    <= '0;
      sa     <= 1'b0;
      sb     <= 1'b0;
      hi     <= '0;
      lo     <= '0;
      dsr    <= '0;
      done   <= 1'b0;
      result <= '0;
    end else if (flush) begin
      state <= IDLE;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE, DONE: begin
          if (accept) begin
            op <= muldiv_op_e'(funct3);
            if (div_zero || div_ovf) begin
              sa    <= 1'b0;
              sb    <= 1'b0;
              cnt   <= '0;
              hi    <= div_zero ? a : '0;
              lo    <= div_zero ? '1 : a;
              state <= FIXUP;
            end else begin
              sa    <= na;
              sb    <= nb;
              cnt   <= CNT_W'(XLEN);
              hi    <= '0;
              lo    <= div_op ? mag_a : mag_b;
              dsr   <= div_op ? mag_b : mag_a;
              state <= CALC;
            end
          end else begin
            state <= IDLE;
          end
        end
        CALC: begin
          hi  <= hi_nxt;
          lo  <= lo_nxt;
          cnt <= cnt - 1'b1;
          if (cnt == CNT_W'(1)) state <= FIXUP;
        end
        FIXUP: begin
          result <= res_nxt;
          done   <= 1'b1;
          state  <= DONE;
        end
      endcase
    end
  end

endmodule
